// File: rtl/sound_seq_pkg.sv
// sound_seq_pkg: opcodes, event codes and FSM states shared by the sound sequencer
package sound_seq_pkg;
  localparam logic [3:0] OP_WAIT     = 4'h0;
  localparam logic [3:0] OP_TEMPO    = 4'h1;
  localparam logic [3:0] OP_VOL      = 4'h2;
  localparam logic [3:0] OP_INST     = 4'h3;
  localparam logic [3:0] OP_NOTE_ON  = 4'h4;
  localparam logic [3:0] OP_NOTE_OFF = 4'h5;
  localparam logic [3:0] OP_END      = 4'hF;
  localparam logic [1:0] EV_VOL      = 2'd0;
  localparam logic [1:0] EV_INST     = 2'd1;
  localparam logic [1:0] EV_NOTE_ON  = 2'd2;
  localparam logic [1:0] EV_NOTE_OFF = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RDWAIT, S_EXEC, S_EMIT, S_DELAY, S_DONE} state_t;
  function automatic logic [1:0] ev_code(input logic [3:0] op);
    return op == OP_VOL ? EV_VOL : op == OP_INST ? EV_INST : op == OP_NOTE_ON ? EV_NOTE_ON : EV_NOTE_OFF;
  endfunction
endpackage

// File: rtl/sound_tick_gen.sv
// sound_tick_gen: base-tick prescaler plus tempo divider (clk/rst, clr, en, tempo in; seq_tick pulse out)
module sound_tick_gen #(
  parameter int TICK_DIV = 1000,
  parameter int TEMPO_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               seq_tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0]      r_pre;
  logic [TEMPO_W-1:0] r_beat;
  logic               w_base;
  assign w_base   = en && r_pre == PW'(TICK_DIV - 1);
  assign seq_tick = w_base && r_beat == tempo - TEMPO_W'(1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pre  <= '0;
      r_beat <= '0;
    end else if (en) begin
      r_pre  <= w_base ? '0 : r_pre + PW'(1);
      r_beat <= seq_tick ? '0 : w_base ? r_beat + TEMPO_W'(1) : r_beat;
    end
  end
endmodule

// File: rtl/sound_seq_reader.sv
// sound_seq_reader: command ROM sequencer (start/abort in, rom_addr/rom_data fetch, ev_* valid/ready events out, busy/done status)
module sound_seq_reader
  import sound_seq_pkg::*;
#(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 16,
  parameter int                TICK_DIV   = 1000,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [1:0]        ev_type,
  output logic [3:0]        ev_chan,
  output logic [7:0]        ev_value,
  output logic              busy,
  output logic              done
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [11:0]       r_tempo;
  logic [11:0]       r_wait;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_type;
  logic [3:0]        r_chan;
  logic [7:0]        r_value;
  logic [3:0]        w_op;
  logic [11:0]       w_arg;
  logic              w_event;
  logic              w_tick;
  assign w_op     = rom_data[DATA_W-1 -: 4];
  assign w_arg    = rom_data[11:0];
  assign w_event  = w_op >= OP_VOL && w_op <= OP_NOTE_OFF;
  assign rom_addr = r_pc;
  assign ev_valid = r_valid;
  assign ev_type  = r_type;
  assign ev_chan  = r_chan;
  assign ev_value = r_value;
  assign busy     = r_busy;
  assign done     = r_done;
  sound_tick_gen #(.TICK_DIV(TICK_DIV), .TEMPO_W(12)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state == S_EXEC),
    .en      (r_state == S_DELAY),
    .tempo   (r_tempo),
    .seq_tick(w_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= START_ADDR;
      r_tempo <= 12'd1;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_type  <= '0;
      r_chan  <= '0;
      r_value <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FETCH;
          r_pc    <= START_ADDR;
          r_busy  <= 1'b1;
        end
        S_FETCH:  r_state <= S_RDWAIT;
        S_RDWAIT: r_state <= S_EXEC;
        S_EXEC: begin
          r_pc <= r_pc + ADDR_W'(1);
          if (w_event) begin
            r_valid <= 1'b1;
            r_type  <= ev_code(w_op);
            r_chan  <= rom_data[11:8];
            r_value <= rom_data[7:0];
            r_state <= S_EMIT;
          end else if (w_op == OP_WAIT && w_arg != '0) begin
            r_wait  <= w_arg;
            r_state <= S_DELAY;
          end else if (w_op == OP_END) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            if (w_op == OP_TEMPO) r_tempo <= w_arg == '0 ? 12'd1 : w_arg;
            r_state <= S_FETCH;
          end
        end
        S_EMIT: if (ev_ready) begin
          r_valid <= 1'b0;
          r_state <= S_FETCH;
        end
        S_DELAY: if (w_tick) begin
          r_wait <= r_wait - 12'd1;
          if (r_wait == 12'd1) r_state <= S_FETCH;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sound_seq_reader.sv
// tb_sound_seq_reader: directed table and sequence checks of the sound sequencer
module tb_sound_seq_reader;
  localparam int TD = 4;
  typedef struct {
    logic [15:0] cmd;
    bit          ev;
    logic [13:0] f;
    int          steps;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, ev_ready = 1, start1 = 0;
  logic [12:0] rom_addr, rom_addr1;
  logic [15:0] rd0, rd1;
  logic ev_valid, busy, done, ev_valid1, busy1, done1;
  logic [1:0] ev_type, ev_type1;
  logic [3:0] ev_chan, ev_chan1;
  logic [7:0] ev_value, ev_value1;
  logic [15:0] rom0 [0:8191];
  logic [15:0] rom1 [0:8191];
  logic [13:0] evq[$];
  logic [13:0] evq1[$];
  logic [3:0] seen;
  int nchk = 0, nerr = 0, ndone = 0, ndone1 = 0;
  logic p_valid = 0, p_ready = 0, p_abort = 0, p_rst = 1;
  logic [13:0] p_f = '0;
  vec_t tbl[15];

  always #5 clk = ~clk;

  sound_seq_reader #(.ADDR_W(13), .DATA_W(16), .TICK_DIV(TD), .START_ADDR(13'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(rom_addr), .rom_data(rd0),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_chan(ev_chan),
    .ev_value(ev_value), .busy(busy), .done(done)
  );
  sound_seq_reader #(.ADDR_W(13), .DATA_W(16), .TICK_DIV(TD), .START_ADDR(13'h1FFF)) dut_wrap (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .rom_addr(rom_addr1), .rom_data(rd1),
    .ev_valid(ev_valid1), .ev_ready(1'b1), .ev_type(ev_type1), .ev_chan(ev_chan1),
    .ev_value(ev_value1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    rd0 <= rom0[rom_addr];
    rd1 <= rom1[rom_addr1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ev_valid && ev_ready) evq.push_back({ev_type, ev_chan, ev_value});
    if (ev_valid1) evq1.push_back({ev_type1, ev_chan1, ev_value1});
    if (done) ndone++;
    if (done1) ndone1++;
    if (busy && rom_addr < 13'd4) seen[rom_addr[1:0]] = 1'b1;
    if (p_valid && !p_ready && !p_abort && !p_rst)
      chk("ev_hold", {ev_valid, ev_type, ev_chan, ev_value}, {1'b1, p_f});
    p_valid = ev_valid;
    p_ready = ev_ready;
    p_abort = abort;
    p_rst   = rst;
    p_f     = {ev_type, ev_chan, ev_value};
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1;
    step;
    start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      step;
      n++;
    end
  endtask

  task automatic clear_roms;
    for (int i = 0; i < 8192; i++) begin
      rom0[i] = 16'hFFFF;
      rom1[i] = 16'hFFFF;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    logic [13:0] cap;
    logic [12:0] a;
    bit ok;
    tbl[0]  = '{16'h2001, 1'b1, {2'd0, 4'h0, 8'h01}, 7};
    tbl[1]  = '{16'h3108, 1'b1, {2'd1, 4'h1, 8'h08}, 7};
    tbl[2]  = '{16'h4020, 1'b1, {2'd2, 4'h0, 8'h20}, 7};
    tbl[3]  = '{16'h5A7F, 1'b1, {2'd3, 4'hA, 8'h7F}, 7};
    tbl[4]  = '{16'h7123, 1'b0, 14'd0, 6};
    tbl[5]  = '{16'h0000, 1'b0, 14'd0, 6};
    tbl[6]  = '{16'h0002, 1'b0, 14'd0, 6 + 2 * 1 * TD};
    tbl[7]  = '{16'h1000, 1'b0, 14'd0, 6};
    tbl[8]  = '{16'h0003, 1'b0, 14'd0, 6 + 3 * 1 * TD};
    tbl[9]  = '{16'h1002, 1'b0, 14'd0, 6};
    tbl[10] = '{16'h0001, 1'b0, 14'd0, 6 + 1 * 2 * TD};
    tbl[11] = '{16'h1000, 1'b0, 14'd0, 6};
    tbl[12] = '{16'h0003, 1'b0, 14'd0, 6 + 3 * 1 * TD};
    tbl[13] = '{16'hE555, 1'b0, 14'd0, 6};
    tbl[14] = '{16'hF123, 1'b0, 14'd0, 3};
    clear_roms;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", rom_addr, 13'h0000);
    chk("rst_addr_wrap", rom_addr1, 13'h1FFF);
    chk("rst_outs", {ev_valid, ev_type, ev_chan, ev_value, busy, done}, 0);
    rst = 0;
    step;

    for (int i = 0; i < 15; i++) begin
      clear_roms;
      rom0[0] = tbl[i].cmd;
      rom0[1] = 16'hF000;
      evq.delete();
      d0 = ndone;
      pulse_start;
      chk($sformatf("vec%0d_busy", i), busy, 1);
      wait_done(n);
      chk($sformatf("vec%0d_steps", i), n, tbl[i].steps);
      chk($sformatf("vec%0d_busy_end", i), busy, 0);
      chk($sformatf("vec%0d_nev", i), evq.size(), tbl[i].ev ? 1 : 0);
      if (evq.size() != 0) chk($sformatf("vec%0d_ev", i), evq[0], tbl[i].f);
      step;
      chk($sformatf("vec%0d_done_pulse", i), {done, ndone - d0}, 1);
    end

    clear_roms;
    rom0[0] = 16'h2001; rom0[1] = 16'h3108; rom0[2] = 16'h4020; rom0[3] = 16'hF000;
    evq.delete();
    seen = '0;
    d0 = ndone;
    pulse_start;
    wait_done(n);
    chk("t1_steps", n, 4 * 3 + 3);
    chk("t1_nev", evq.size(), 3);
    if (evq.size() == 3) begin
      chk("t1_ev0", evq[0], {2'd0, 4'h0, 8'h01});
      chk("t1_ev1", evq[1], {2'd1, 4'h1, 8'h08});
      chk("t1_ev2", evq[2], {2'd2, 4'h0, 8'h20});
    end
    chk("t1_busy", busy, 0);
    chk("t1_seen", seen, 4'hF);
    step;
    chk("t1_ndone", ndone - d0, 1);

    clear_roms;
    rom0[0] = 16'h1003; rom0[1] = 16'h0002; rom0[2] = 16'h4022; rom0[3] = 16'hF000;
    pulse_start;
    n = 0;
    while (rom_addr != 13'd2 && n < 50) begin step; n++; end
    n = 0;
    while (rom_addr == 13'd2 && n < 200) begin step; n++; end
    chk("t2_wait_clk", n, 2 * 3 * TD + 3);
    chk("t2_ev", {ev_valid, ev_type, ev_chan, ev_value}, {1'b1, 2'd2, 4'h0, 8'h22});
    wait_done(n);
    step;

    clear_roms;
    rom0[0] = 16'h4020; rom0[1] = 16'h2105; rom0[2] = 16'hF000;
    evq.delete();
    ev_ready = 0;
    pulse_start;
    n = 0;
    while (!ev_valid && n < 20) begin step; n++; end
    chk("t3_first_ev", {ev_valid, ev_type, ev_chan, ev_value}, {1'b1, 2'd2, 4'h0, 8'h20});
    cap = {ev_type, ev_chan, ev_value};
    a = rom_addr;
    ok = 1;
    repeat (10) begin
      step;
      if (!ev_valid || {ev_type, ev_chan, ev_value} != cap || rom_addr != a) ok = 0;
    end
    chk("t3_stable", ok, 1);
    chk("t3_addr", a, 13'd1);
    ev_ready = 1;
    step;
    chk("t3_release", ev_valid, 0);
    wait_done(n);
    chk("t3_nev", evq.size(), 2);
    if (evq.size() == 2) chk("t3_ev1", evq[1], {2'd0, 4'h1, 8'h05});
    step;

    rom1[13'h1FFF] = 16'h4030;
    rom1[0] = 16'hF000;
    evq1.delete();
    d0 = ndone1;
    start1 = 1;
    step;
    start1 = 0;
    n = 0;
    while (!done1 && n < 100) begin step; n++; end
    chk("t4_steps", n, 7);
    chk("t4_nev", evq1.size(), 1);
    if (evq1.size() == 1) chk("t4_ev", evq1[0], {2'd2, 4'h0, 8'h30});
    chk("t4_addr", rom_addr1, 13'h0001);
    step;
    chk("t4_ndone", ndone1 - d0, 1);

    clear_roms;
    rom0[0] = 16'h0005; rom0[1] = 16'h2001; rom0[2] = 16'hF000;
    evq.delete();
    d0 = ndone;
    pulse_start;
    repeat (10) step;
    chk("t5_delay_busy", busy, 1);
    abort = 1;
    step;
    abort = 0;
    chk("t5_abort_delay", {busy, ev_valid, done}, 0);
    repeat (30) step;
    chk("t5_abort_delay_quiet", {evq.size(), ndone - d0}, 0);

    rom0[0] = 16'h4020; rom0[1] = 16'hF000;
    ev_ready = 0;
    pulse_start;
    n = 0;
    while (!ev_valid && n < 20) begin step; n++; end
    chk("t5_emit_valid", ev_valid, 1);
    abort = 1;
    step;
    abort = 0;
    ev_ready = 1;
    chk("t5_abort_emit", {busy, ev_valid, done}, 0);
    repeat (10) step;
    chk("t5_abort_emit_quiet", {evq.size(), ndone - d0}, 0);

    abort = 1;
    start = 1;
    step;
    abort = 0;
    start = 0;
    chk("t5_abort_wins", busy, 0);
    repeat (5) step;
    chk("t5_abort_wins_idle", {busy, ndone - d0}, 0);

    rom0[0] = 16'h0005;
    rom0[1] = 16'h2001;
    rom0[2] = 16'hF000;
    pulse_start;
    repeat (10) step;
    rst = 1;
    step;
    rst = 0;
    chk("t5_rst_state", {rom_addr, ev_valid, ev_type, ev_chan, ev_value, busy, done}, 0);
    rom0[0] = 16'h0002;
    pulse_start;
    wait_done(n);
    chk("t5_restart_steps", n, 3 + 2 * 1 * TD + 4 + 3);
    chk("t5_restart_ev", evq.size() == 1 ? evq[0] : 14'h3FFF, {2'd0, 4'h0, 8'h01});
    step;

    evq.delete();
    d0 = ndone;
    pulse_start;
    repeat (4) step;
    pulse_start;
    wait_done(n);
    chk("t6_start_busy_steps", 4 + 1 + n, 3 + 2 * 1 * TD + 4 + 3);
    chk("t6_start_busy_nev", evq.size(), 1);
    step;
    chk("t6_start_busy_ndone", ndone - d0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
